// File: rtl/mem_io_responder_if.sv
// rtl/mem_io_responder_if.sv - core memory bus plus TX/RX byte streams between the CPU side and the responder
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        prog_end;
    logic        tx_overflow;

    modport master (
        output mem_a, mem_wr, mem_dout, tx_ready, rx_valid, rx_data,
        input  mem_din, io_buffer_full, tx_valid, tx_data, rx_ready, prog_end, tx_overflow
    );

    modport slave (
        input  mem_a, mem_wr, mem_dout, tx_ready, rx_valid, rx_data,
        output mem_din, io_buffer_full, tx_valid, tx_data, rx_ready, prog_end, tx_overflow
    );
endinterface

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - main RAM with registered reads, IO window with TX FIFO and optional RX FIFO (MEM_RESP_RX_EN)
module mem_io_responder #(
    parameter int RAM_ADDR_WID = 16,
    parameter int FIFO_AW      = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_io_responder_if.slave   bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] ALMOST_FULL = (FIFO_AW+1)'(DEPTH - 2);

    logic                    io_sel;
    logic                    hit_data;
    logic                    hit_end;
    logic [RAM_ADDR_WID-1:0] ram_idx;
    logic                    prev_data;
    logic [7:0]              din_next;

    logic [7:0] ram [2**RAM_ADDR_WID];

    assign io_sel   = (bus.mem_a[17:16] == 2'b11);
    assign hit_data = (bus.mem_a[17:0] == 18'h30000);
    assign hit_end  = (bus.mem_a[17:0] == 18'h30004);
    assign ram_idx  = bus.mem_a[RAM_ADDR_WID-1:0];

    // ---------------- TX FIFO ----------------
    logic [7:0]       tx_mem [DEPTH];
    logic [FIFO_AW:0] tx_wptr, tx_rptr, tx_count;
    logic             tx_empty, tx_full, tx_req, tx_push, tx_pop;

    assign tx_count = tx_wptr - tx_rptr;
    assign tx_empty = (tx_count == '0);
    assign tx_full  = tx_count[FIFO_AW];
    assign tx_pop   = !tx_empty && bus.tx_ready;
    assign tx_req   = bus.mem_wr && hit_data;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign tx_push  = tx_req && (!tx_full || tx_pop);

    assign bus.tx_valid = !tx_empty;
    assign bus.tx_data  = tx_mem[tx_rptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wptr[FIFO_AW-1:0]] <= bus.mem_dout;
    end

    // ---------------- RX FIFO (optional) ----------------
    logic       rx_pop;
    logic       rx_avail;
    logic [7:0] rx_head;

`ifdef MEM_RESP_RX_EN
    logic [7:0]       rx_mem [DEPTH];
    logic [FIFO_AW:0] rx_wptr, rx_rptr, rx_count;
    logic             rx_full, rx_push;

    assign rx_count     = rx_wptr - rx_rptr;
    assign rx_full      = rx_count[FIFO_AW];
    assign rx_avail     = (rx_count != '0);
    assign bus.rx_ready = !rx_full;
    assign rx_push      = bus.rx_valid && !rx_full;
    assign rx_head      = rx_mem[rx_rptr[FIFO_AW-1:0]];
    // A stalled core holds the address for several cycles; pop only on the first
    assign rx_pop       = !bus.mem_wr && hit_data && !prev_data && rx_avail;

    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wptr[FIFO_AW-1:0]] <= bus.rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
        end
    end
`else
    logic unused_rx;
    assign unused_rx    = ^{bus.rx_valid, bus.rx_data};
    assign bus.rx_ready = 1'b0;
    assign rx_avail     = 1'b0;
    assign rx_pop       = 1'b0;
    assign rx_head      = 8'h00;
`endif

    logic unused_addr;
    assign unused_addr = ^{bus.mem_a[31:18], rx_avail};

    // ---------------- RAM and read data ----------------
    always_ff @(posedge clk) begin
        if (bus.mem_wr && !io_sel)
            ram[ram_idx] <= bus.mem_dout;
    end

    always_comb begin
        din_next = 8'h00;
        if (!bus.mem_wr) begin
            if (!io_sel)
                din_next = ram[ram_idx];
            else if (rx_pop)
                din_next = rx_head;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.mem_din        <= 8'h00;
            bus.io_buffer_full <= 1'b0;
            bus.prog_end       <= 1'b0;
            bus.tx_overflow    <= 1'b0;
            prev_data          <= 1'b0;
            tx_wptr            <= '0;
            tx_rptr            <= '0;
        end else begin
            bus.mem_din        <= din_next;
            bus.io_buffer_full <= (tx_count >= ALMOST_FULL);
            bus.prog_end       <= bus.mem_wr && hit_end;
            if (tx_req && !tx_push)
                bus.tx_overflow <= 1'b1;
            prev_data <= hit_data;
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - directed vector bench for mem_io_responder
module tb_mem_io_responder;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_io_responder_if bus();

    mem_io_responder #(.RAM_ADDR_WID(16), .FIFO_AW(4)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef MEM_RESP_RX_EN
    localparam logic RX_READY_IDLE = 1'b1;
`else
    localparam logic RX_READY_IDLE = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  dout;
        logic [7:0]  exp_din;
        logic        exp_pe;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.mem_wr   = 1'b0;
        bus.mem_a    = 32'h0;
        bus.mem_dout = 8'h00;
    endtask

    initial begin
        int hits41, hits42;
        vecs[0]  = '{1'b1, 32'h00010,     8'hA5, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 32'h00010,     8'h00, 8'hA5, 1'b0};
        vecs[2]  = '{1'b1, 32'h00010,     8'h11, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 32'h00011,     8'h22, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 32'h00012,     8'h33, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, 32'h00013,     8'h44, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 32'h00010,     8'h00, 8'h11, 1'b0};
        vecs[7]  = '{1'b0, 32'h00011,     8'h00, 8'h22, 1'b0};
        vecs[8]  = '{1'b0, 32'h00012,     8'h00, 8'h33, 1'b0};
        vecs[9]  = '{1'b0, 32'h00013,     8'h00, 8'h44, 1'b0};
        vecs[10] = '{1'b0, 32'h00020012,  8'h00, 8'h33, 1'b0};
        vecs[11] = '{1'b1, 32'h00030004,  8'h5A, 8'h00, 1'b1};
        vecs[12] = '{1'b0, 32'h00030008,  8'h00, 8'h00, 1'b0};
        vecs[13] = '{1'b1, 32'h00030008,  8'h77, 8'h00, 1'b0};
        vecs[14] = '{1'b0, 32'hFFFC0013,  8'h00, 8'h44, 1'b0};

        rst_n        = 1'b0;
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        idle();
        #2;
        check("rst_mem_din",        32'(bus.mem_din),        32'h00);
        check("rst_tx_valid",       32'(bus.tx_valid),       32'h0);
        check("rst_io_buffer_full", 32'(bus.io_buffer_full), 32'h0);
        check("rst_prog_end",       32'(bus.prog_end),       32'h0);
        check("rst_tx_overflow",    32'(bus.tx_overflow),    32'h0);
        check("rst_rx_ready",       32'(bus.rx_ready),       32'(RX_READY_IDLE));
        step();
        rst_n = 1'b1;
        step();

        // RAM and IO-decode vectors
        for (int i = 0; i < 15; i++) begin
            bus.mem_wr   = vecs[i].wr;
            bus.mem_a    = vecs[i].addr;
            bus.mem_dout = vecs[i].dout;
            step();
            check($sformatf("vec%0d_mem_din", i),  32'(bus.mem_din),  32'(vecs[i].exp_din));
            check($sformatf("vec%0d_prog_end", i), 32'(bus.prog_end), 32'(vecs[i].exp_pe));
        end
        idle();
        step();
        check("tx_untouched", 32'(bus.tx_valid), 32'h0);

        // TX fill with a stalled consumer
        for (int i = 0; i < 17; i++) begin
            bus.mem_wr   = 1'b1;
            bus.mem_a    = 32'h30000;
            bus.mem_dout = 8'(i);
            step();
            if (i == 12) check("almost_full_13", 32'(bus.io_buffer_full), 32'h0);
            if (i == 14) check("almost_full_15", 32'(bus.io_buffer_full), 32'h1);
            if (i == 15) check("no_ovf_16",      32'(bus.tx_overflow),    32'h0);
            if (i == 16) check("ovf_17",         32'(bus.tx_overflow),    32'h1);
        end
        idle();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d_valid", i), 32'(bus.tx_valid), 32'h1);
            check($sformatf("drain%0d_data", i),  32'(bus.tx_data),  32'(i));
            step();
        end
        check("drain_empty",     32'(bus.tx_valid),       32'h0);
        check("ovf_sticky",      32'(bus.tx_overflow),    32'h1);
        check("drain_not_full",  32'(bus.io_buffer_full), 32'h0);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("ovf_cleared", 32'(bus.tx_overflow), 32'h0);

        // TX streaming: push and pop every cycle
        for (int i = 0; i < 8; i++) begin
            bus.mem_wr   = 1'b1;
            bus.mem_a    = 32'h30000;
            bus.mem_dout = 8'(8'h50 + i);
            step();
            check($sformatf("stream%0d_valid", i), 32'(bus.tx_valid), 32'h1);
            check($sformatf("stream%0d_data", i),  32'(bus.tx_data),  32'(8'h50 + i));
        end
        idle();
        step();
        check("stream_empty", 32'(bus.tx_valid),    32'h0);
        check("stream_noovf", 32'(bus.tx_overflow), 32'h0);
        bus.tx_ready = 1'b0;

        // RX reads through the IO window
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h41;
        step();
        bus.rx_data  = 8'h42;
        step();
        bus.rx_valid = 1'b0;
`ifdef MEM_RESP_RX_EN
        hits41 = 0;
        hits42 = 0;
        bus.mem_a = 32'h30000;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.mem_din == 8'h41) hits41++;
            if (bus.mem_din == 8'h42) hits42++;
        end
        check("rx_held_pops_41_once", 32'(hits41), 32'd1);
        check("rx_held_no_42",        32'(hits42), 32'd0);
        bus.mem_a = 32'h00010;
        step();
        bus.mem_a = 32'h30000;
        step();
        check("rx_second", 32'(bus.mem_din), 32'h42);
        bus.mem_a = 32'h00010;
        step();
        bus.mem_a = 32'h30000;
        step();
        check("rx_empty", 32'(bus.mem_din), 32'h00);
        check("rx_ready_after", 32'(bus.rx_ready), 32'h1);
`else
        hits41 = 0;
        hits42 = 0;
        bus.rx_valid = 1'b1;
        bus.mem_a = 32'h30000;
        step();
        check("rx_disabled_read", 32'(bus.mem_din), 32'h00);
        check("rx_disabled_ready", 32'(bus.rx_ready), 32'h0);
        check("rx_disabled_hits", 32'(hits41 + hits42), 32'd0);
        bus.rx_valid = 1'b0;
`endif
        idle();
        step();

        // Async reset mid-stream with FIFOs partly filled
        for (int i = 0; i < 8; i++) begin
            bus.mem_wr   = 1'b1;
            bus.mem_a    = 32'h30000;
            bus.mem_dout = 8'(8'hC0 + i);
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'(8'hD0 + i);
            step();
        end
        bus.rx_valid = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.mem_a    = 32'h00010;
        step();
        check("pre_rst_din",   32'(bus.mem_din),  32'h11);
        check("pre_rst_valid", 32'(bus.tx_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_din",   32'(bus.mem_din),  32'h00);
        check("async_rst_valid", 32'(bus.tx_valid), 32'h0);
        check("async_rst_ready", 32'(bus.rx_ready), 32'(RX_READY_IDLE));
        bus.mem_a = 32'h0;
        step();
        rst_n = 1'b1;
        bus.mem_a = 32'h30000;
        step();
        check("post_rst_rx_empty", 32'(bus.mem_din),  32'h00);
        check("post_rst_tx_empty", 32'(bus.tx_valid), 32'h0);
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
